// File: rtl/pq_shiftreg_if.sv
// Shared HWPQ types and the queue-side port bundle.
// Pairs are <key,value>; empty cells hold KV_EMPTY.
package pq_pkg;

  localparam int PQ_CAPACITY = 15;
  localparam logic [7:0] KEYINF = 8'hFF;

  typedef enum logic {
    MIN_PQ = 1'b0,
    MAX_PQ = 1'b1
  } pq_type_e;

  localparam pq_type_e PQ_TYPE = MIN_PQ;

  typedef struct packed {
    logic [7:0] key;
    logic [7:0] val;
  } kv_t;

  localparam kv_t KV_EMPTY = '{
    key: KEYINF,
    val: 8'h00
  };

endpackage

interface pq_shiftreg_if
  import pq_pkg::*;
#(
  parameter int CAPACITY = PQ_CAPACITY
);

  localparam int CW = $clog2(CAPACITY + 1);

  logic          enq;
  logic          deq;
  kv_t           kvi;
  kv_t           kvo;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          ovf;
  logic          udf;

  modport master (
    output enq,
    output deq,
    output kvi,
    input  kvo,
    input  full,
    input  empty,
    input  count,
    input  ovf,
    input  udf
  );

  modport slave (
    input  enq,
    input  deq,
    input  kvi,
    output kvo,
    output full,
    output empty,
    output count,
    output ovf,
    output udf
  );

endinterface

// File: rtl/pq_shiftreg.sv
// Sorted shift-register priority queue, head at q[0].
// Enqueue, dequeue or replace completes in one clock.
module pq_shiftreg
  import pq_pkg::*;
#(
  parameter int       CAPACITY = PQ_CAPACITY,
  parameter pq_type_e TYPE     = PQ_TYPE
) (
  input logic         clk,
  input logic         rst_n,
  pq_shiftreg_if.slave pq
);

  localparam int CW = $clog2(CAPACITY + 1);
  localparam logic [CW-1:0] CAP_C =
    CW'(CAPACITY);

  kv_t           q   [CAPACITY];
  kv_t           s   [CAPACITY];
  kv_t           n   [CAPACITY];
  logic [CW-1:0] cnt;
  logic [CW-1:0] ec;
  logic [CW-1:0] nxt_cnt;
  logic          do_enq;
  logic          do_deq;
  logic          ovf_q;
  logic          udf_q;
  logic          ovf_d;
  logic          udf_d;
  logic          seen;
  logic          ins;

  function automatic logic better(
    input kv_t a,
    input kv_t b
  );
    if (TYPE == MIN_PQ) begin
      return a.key < b.key;
    end
    return a.key > b.key;
  endfunction

  // s is the array after an optional head removal;
  // the insert position is searched against it.
  always_comb begin
    do_deq = pq.deq && (cnt != '0);
    ec     = do_deq ? cnt - 1'b1 : cnt;
    do_enq = pq.enq && (ec < CAP_C);
    ovf_d  = pq.enq && !do_enq;
    udf_d  = pq.deq && (cnt == '0);

    for (int i = 0; i < CAPACITY - 1; i++) begin
      s[i] = do_deq ? q[i+1] : q[i];
    end
    s[CAPACITY-1] = do_deq ? KV_EMPTY
                           : q[CAPACITY-1];

    // Occupancy bound, not a KEYINF compare,
    // so a KEYINF key still lands correctly.
    ins  = (ec == '0) || better(pq.kvi, s[0]);
    n[0] = (do_enq && ins) ? pq.kvi : s[0];
    seen = ins;
    for (int i = 1; i < CAPACITY; i++) begin
      ins = (CW'(i) >= ec)
         || better(pq.kvi, s[i]);
      if (!do_enq) begin
        n[i] = s[i];
      end else if (seen) begin
        n[i] = s[i-1];
      end else if (ins) begin
        n[i] = pq.kvi;
      end else begin
        n[i] = s[i];
      end
      seen = seen || ins;
    end

    nxt_cnt = cnt;
    unique case (1'b1)
      do_enq && !do_deq: nxt_cnt = cnt + 1'b1;
      do_deq && !do_enq: nxt_cnt = cnt - 1'b1;
      do_enq == do_deq:  nxt_cnt = cnt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CAPACITY; i++) begin
        q[i] <= KV_EMPTY;
      end
      cnt   <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      for (int i = 0; i < CAPACITY; i++) begin
        q[i] <= n[i];
      end
      cnt   <= nxt_cnt;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign pq.kvo   = q[0];
  assign pq.count = cnt;
  assign pq.full  = (cnt == CAP_C);
  assign pq.empty = (cnt == '0);
  assign pq.ovf   = ovf_q;
  assign pq.udf   = udf_q;

endmodule
